// File: rtl/mdc_pkg.sv
// Shared definitions for the MDC result path.
//   MDC_OUT_W  : width of one MDC determinant result
//   SER_OUT_W  : width of one serialized output chunk
//   num_chunks : number of chunks needed to carry one result
//   ser_state_e: serializer control states
package mdc_pkg;

    localparam int unsigned MDC_OUT_W = 207;
    localparam int unsigned SER_OUT_W = 16;

    // Ceiling division: a partial top chunk still costs a full transfer.
    function automatic int unsigned num_chunks(input int unsigned in_w,
                                               input int unsigned out_w);
        return (in_w + out_w - 1) / out_w;
    endfunction

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } ser_state_e;

endpackage

// File: rtl/mdc_result_fifo2.sv
// Two-entry result buffer sitting between the MDC and the serializer.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset, empties the buffer
//   push_i   : write wdata_i this cycle (ignored when full unless pop_i is also high)
//   wdata_i  : result to store
//   pop_i    : retire the head entry (ignored when empty)
//   head_o   : oldest entry
//   next_o   : entry behind the head (valid only when count_o == 2)
//   count_o  : occupancy 0..2
module mdc_result_fifo2 #(
    parameter int unsigned Width = 207
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [Width-1:0] next_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    logic do_push;
    logic do_pop;

    always_comb begin
        do_pop  = pop_i & (count_q != 2'd0);
        // When full, a simultaneous pop frees the head slot, which the write pointer
        // already points at, so the new entry lands in it.
        do_push = push_i & ((count_q != 2'd2) | do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[~rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mdc_result_serializer.sv
// Captures MDC results into a 2-entry buffer and streams each one out as
// OUT_W-bit chunks, least-significant chunk first, over valid/ready.
//   clk       : clock, rising edge
//   rst_n     : synchronous reset, ACTIVE HIGH despite the name
//   in_valid  : one-cycle result strobe from the MDC
//   in_data   : MDC result, sampled when in_valid is high
//   out_valid : out_data carries a valid chunk
//   out_data  : current chunk (zero when out_valid is low)
//   out_last  : current chunk is the final one of the result
//   out_ready : consumer accepts the chunk this cycle
//   overflow  : one-cycle pulse after a result had to be dropped
//   busy      : at least one buffer slot is occupied
module mdc_result_serializer
    import mdc_pkg::*;
#(
    parameter int unsigned IN_W  = MDC_OUT_W,
    parameter int unsigned OUT_W = SER_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned NUM_CHUNKS = num_chunks(IN_W, OUT_W);
    localparam int unsigned IdxW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned PadW       = NUM_CHUNKS * OUT_W;
    localparam logic [IdxW-1:0] LastIdx     = IdxW'(NUM_CHUNKS - 1);
    localparam logic            SingleChunk = (NUM_CHUNKS == 1);

    // Chunk k of a result; the top chunk is zero-extended.
    function automatic logic [OUT_W-1:0] get_chunk(input logic [IN_W-1:0] d,
                                                   input logic [IdxW-1:0] k);
        logic [PadW-1:0]  p;
        logic [OUT_W-1:0] r;
        p           = '0;
        p[IN_W-1:0] = d;
        r           = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (k == IdxW'(i)) begin
                r = p[i*OUT_W +: OUT_W];
            end
        end
        return r;
    endfunction

    ser_state_e       state_q;
    logic [IdxW-1:0]  idx_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_last_q;
    logic             overflow_q;
    logic             busy_q;

    logic [IN_W-1:0]  fifo_head;
    logic [IN_W-1:0]  fifo_next;
    logic [1:0]       fifo_count;

    logic             xfer;
    logic             last_xfer;
    logic             accept;
    logic             more;
    logic [IN_W-1:0]  next_head;
    logic [1:0]       count_nxt;
    logic [IdxW-1:0]  idx_inc;

    always_comb begin
        xfer      = out_valid_q & out_ready;
        last_xfer = xfer & out_last_q;
        // A full buffer can still take a result if the head retires this cycle.
        accept    = in_valid & ((fifo_count != 2'd2) | last_xfer);
        count_nxt = fifo_count + 2'(accept) - 2'(last_xfer);
        more      = (fifo_count == 2'd2) | accept;
        // Entry that becomes head once the current one retires: the buffered
        // second entry if there is one, otherwise the result arriving right now.
        next_head = (fifo_count == 2'd2) ? fifo_next : in_data;
        idx_inc   = idx_q + IdxW'(1);
    end

    mdc_result_fifo2 #(
        .Width (IN_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .push_i  (accept),
        .wdata_i (in_data),
        .pop_i   (last_xfer),
        .head_o  (fifo_head),
        .next_o  (fifo_next),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            overflow_q <= in_valid & ~accept;
            busy_q     <= (count_nxt != 2'd0);
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (!out_valid_q) begin
                        // First result after idle: head was written last edge.
                        out_valid_q <= 1'b1;
                        out_data_q  <= get_chunk(fifo_head, '0);
                        out_last_q  <= SingleChunk;
                        idx_q       <= '0;
                    end else if (xfer) begin
                        if (out_last_q) begin
                            idx_q <= '0;
                            if (more) begin
                                // Chain straight into the next result, no bubble.
                                out_data_q <= get_chunk(next_head, '0);
                                out_last_q <= SingleChunk;
                            end else begin
                                out_valid_q <= 1'b0;
                                out_data_q  <= '0;
                                out_last_q  <= 1'b0;
                                state_q     <= StIdle;
                            end
                        end else begin
                            idx_q      <= idx_inc;
                            out_data_q <= get_chunk(fifo_head, idx_inc);
                            out_last_q <= (idx_inc == LastIdx);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mdc_result_serializer.sv
module tb_mdc_result_serializer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [206:0] in_data;
    logic         out_valid;
    logic [15:0]  out_data;
    logic         out_last;
    logic         out_ready;
    logic         overflow;
    logic         busy;

    int tests;
    int fails;

    mdc_result_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Test vectors: 0 = 1<<192 | ABCD, 1 = all ones, 3 = 0x12345678, other = 0
    function automatic logic [206:0] vec(input int kind);
        logic [206:0] v;
        case (kind)
            0:       v = (207'h1 << 192) | 207'hABCD;
            1:       v = '1;
            3:       v = 207'h1234_5678;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Hand-worked chunk tables for the vectors above.
    function automatic logic [15:0] hand_chunk(input int kind, input int k);
        logic [15:0] c;
        case (kind)
            0:       c = (k == 0) ? 16'hABCD : ((k == 12) ? 16'h0001 : 16'h0000);
            1:       c = (k == 12) ? 16'h7FFF : 16'hFFFF;
            3:       c = (k == 0) ? 16'h5678 : ((k == 1) ? 16'h1234 : 16'h0000);
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = vec(1);
        tick();
        tick();
        tests++;
        if ({out_valid, out_last, out_data, overflow, busy} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h ov=%b busy=%b, want all 0",
                     out_valid, out_last, out_data, overflow, busy);
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tests++;
        if ({out_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL reset_release: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_data   = vec(0);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        tests++;
        if ({out_valid, busy} !== 2'b01) begin
            fails++;
            $display("FAIL single_latency: got v=%b busy=%b, want v=0 busy=1", out_valid, busy);
        end
        tick();
        for (int k = 0; k < 13; k++) begin
            tests++;
            if ({out_valid, out_last, out_data, busy} !== {1'b1, k == 12, hand_chunk(0, k), 1'b1})
            begin
                fails++;
                $display("FAIL single_chunk%0d: got v=%b l=%b d=%h busy=%b, want 1 %b %h 1",
                         k, out_valid, out_last, out_data, busy, k == 12, hand_chunk(0, k));
            end
            tick();
        end
        tests++;
        if ({out_valid, out_data, busy} !== 18'h0) begin
            fails++;
            $display("FAIL single_end: got v=%b d=%h busy=%b, want 0 0 0",
                     out_valid, out_data, busy);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int stall;
        n         = 0;
        stall     = 0;
        out_ready = 1'b1;
        in_data   = vec(0);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int c = 0; c < 80 && n < 13; c++) begin
            out_ready = (c % 3 == 0);
            stall     = 0;
            if (out_valid) begin
                if (out_ready) begin
                    tests++;
                    if ({out_last, out_data} !== {n == 12, hand_chunk(0, n)}) begin
                        fails++;
                        $display("FAIL bp_xfer%0d: got l=%b d=%h, want %b %h",
                                 n, out_last, out_data, n == 12, hand_chunk(0, n));
                    end
                    n++;
                end else begin
                    stall = 1;
                end
            end
            tick();
            if (stall != 0) begin
                tests++;
                if ({out_valid, out_last, out_data} !== {1'b1, n == 12, hand_chunk(0, n)}) begin
                    fails++;
                    $display("FAIL bp_stall%0d: got v=%b l=%b d=%h, want 1 %b %h",
                             n, out_valid, out_last, out_data, n == 12, hand_chunk(0, n));
                end
            end
        end
        tests++;
        if (n !== 13 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_count: got %0d transfers v=%b, want 13 transfers v=0", n, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int ov_seen;
        ov_seen   = 0;
        out_ready = 1'b1;
        in_data   = vec(1);
        in_valid  = 1'b1;
        tick();
        in_data = vec(2);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < 26; i++) begin
            if (overflow) ov_seen = 1;
            tests++;
            if ({out_valid, out_last, out_data} !==
                {1'b1, (i % 13) == 12, hand_chunk((i < 13) ? 1 : 2, i % 13)}) begin
                fails++;
                $display("FAIL b2b_chunk%0d: got v=%b l=%b d=%h, want 1 %b %h", i, out_valid,
                         out_last, out_data, (i % 13) == 12, hand_chunk((i < 13) ? 1 : 2, i % 13));
            end
            tick();
        end
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ov_seen != 0) begin
            fails++;
            $display("FAIL b2b_end: got v=%b busy=%b overflow_seen=%0d, want 0 0 0",
                     out_valid, busy, ov_seen);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = vec(0);
        tick();
        in_data = vec(1);
        tick();
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_early: got overflow=%b, want 0", overflow);
        end
        in_data = vec(3);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_pulse: got overflow=%b, want 1", overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 26; i++) begin
            tests++;
            if ({out_valid, out_last, out_data} !==
                {1'b1, (i % 13) == 12, hand_chunk((i < 13) ? 0 : 1, i % 13)}) begin
                fails++;
                $display("FAIL ovf_chunk%0d: got v=%b l=%b d=%h, want 1 %b %h", i, out_valid,
                         out_last, out_data, (i % 13) == 12, hand_chunk((i < 13) ? 0 : 1, i % 13));
            end
            tick();
            if (i == 0) begin
                tests++;
                if (overflow !== 1'b0) begin
                    fails++;
                    $display("FAIL ovf_one_cycle: got overflow=%b, want 0", overflow);
                end
            end
        end
        tick();
        tests++;
        if ({out_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL ovf_dropped: got v=%b busy=%b, want 0 0 (C must not stream)",
                     out_valid, busy);
        end
    endtask

    task automatic test_pop_push();
        int kinds [3];
        int ov_seen;
        kinds     = '{1, 0, 3};
        ov_seen   = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = vec(1);
        tick();
        in_data = vec(0);
        tick();
        for (int i = 0; i < 39; i++) begin
            // Cycle 12 carries A's last-chunk handshake while B is still buffered.
            in_valid = (i == 12);
            in_data  = (i == 12) ? vec(3) : '0;
            if (i == 12) begin
                tests++;
                if (out_last !== 1'b1 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL pp_setup: got l=%b busy=%b, want 1 1", out_last, busy);
                end
            end
            tests++;
            if ({out_valid, out_last, out_data} !==
                {1'b1, (i % 13) == 12, hand_chunk(kinds[i / 13], i % 13)}) begin
                fails++;
                $display("FAIL pp_chunk%0d: got v=%b l=%b d=%h, want 1 %b %h", i, out_valid,
                         out_last, out_data, (i % 13) == 12, hand_chunk(kinds[i / 13], i % 13));
            end
            tick();
            if (overflow) ov_seen = 1;
        end
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ov_seen != 0) begin
            fails++;
            $display("FAIL pp_end: got v=%b busy=%b overflow_seen=%0d, want 0 0 0",
                     out_valid, busy, ov_seen);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = vec(1);
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if ({out_valid, out_data} !== {1'b1, 16'hFFFF}) begin
            fails++;
            $display("FAIL rst_pre: got v=%b d=%h, want 1 ffff", out_valid, out_data);
        end
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = vec(3);
        tick();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tests++;
        if ({out_valid, out_last, out_data, overflow, busy} !== 20'h0) begin
            fails++;
            $display("FAIL rst_mid: got v=%b l=%b d=%h ov=%b busy=%b, want all 0",
                     out_valid, out_last, out_data, overflow, busy);
        end
        tick();
        tests++;
        if ({out_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL rst_ignored_in: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
        in_valid = 1'b1;
        in_data  = vec(0);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        for (int k = 0; k < 13; k++) begin
            tests++;
            if ({out_valid, out_last, out_data} !== {1'b1, k == 12, hand_chunk(0, k)}) begin
                fails++;
                $display("FAIL rst_restart%0d: got v=%b l=%b d=%h, want 1 %b %h",
                         k, out_valid, out_last, out_data, k == 12, hand_chunk(0, k));
            end
            tick();
        end
        tests++;
        if ({out_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL rst_restart_end: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_pop_push();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdc_result_serializer.md
Name: mdc_result_serializer

Overview:
- Downstream stage of the MDC (matrix determinant calculator).
- Captures each 207-bit MDC result on its one-cycle out_valid pulse and holds it in a 2-entry buffer.
- Streams the result as fixed-width chunks, least-significant chunk first, over a valid/ready interface toward the narrow output port or host logic.
- MDC has no backpressure input, so this block absorbs back-to-back results and flags any drop.

Parameters:
- IN_W, 207, result width; must match MDC out_data.
- OUT_W, 16, chunk width.
- NUM_CHUNKS, ceil(IN_W/OUT_W) = 13, derived as a localparam and not overridable.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-high reset: 1 = reset, sampled on clk edge; the name is kept for port compatibility.
- in_valid  input  1  driven by MDC out_valid; one-cycle pulse per result.
- in_data  input  IN_W  driven by MDC out_data; sampled only when in_valid=1.
- out_valid  output  1  chunk on out_data is valid.
- out_data  output  OUT_W  current chunk.
- out_last  output  1  high with the final chunk (index NUM_CHUNKS-1).
- out_ready  input  1  consumer accepts; a chunk transfers when out_valid & out_ready.
- overflow  output  1  one-cycle pulse when an incoming result is dropped.
- busy  output  1  high while either buffer slot is occupied.

Behaviour:
- Reset (rst_n=1 at an edge): out_valid=0, out_data=0, out_last=0, overflow=0, busy=0. Both slots are emptied and the chunk index is cleared.
  - Reset mid-stream aborts the current result; no partial completion.
  - in_valid in a reset cycle is ignored.
- Buffer: 2-entry FIFO with write pointer, read pointer and count 0..2.
- Accept rule: in_valid is written when count<2, or when count==2 and the last-chunk handshake (out_valid & out_ready & out_last) occurs in the same cycle. In that case the freed slot is reused.
- Drop rule: otherwise in_data is discarded, overflow=1 the next cycle for exactly one cycle, and buffer contents are unchanged.
- FSM states:
  - IDLE: count==0.
  - SEND: the head slot is being streamed.
- FSM transitions:
  - IDLE -> SEND on accept.
  - SEND -> SEND on last-chunk handshake when another entry remains or one is accepted that cycle; the index resets to 0.
  - SEND -> IDLE on last-chunk handshake with nothing left.
- Latency: in_valid at edge t with FIFO empty gives out_valid=1 with chunk 0 after edge t+1. No bubble between consecutive buffered results.
- Chunking: chunk k = head[OUT_W*k +: OUT_W] for k<NUM_CHUNKS-1. The final chunk is head[IN_W-1 : OUT_W*(NUM_CHUNKS-1)], zero-extended; for the defaults that is {1'b0, head[206:192]}.
- Handshake:
  - All outputs are registered.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never drops without a transfer except on reset.
  - out_ready is ignored when out_valid=0.
- out_data=0 whenever out_valid=0.
- Chunk index advances 0..NUM_CHUNKS-1 only on a transfer and wraps to 0 after last.
- busy = (count!=0), registered alongside count.

Decomposition:
- mdc_pkg holds:
  - MDC_OUT_W=207 and SER_OUT_W=16.
  - The NUM_CHUNKS computation function.
  - The state enum {IDLE, SEND}.
- One sub-module: mdc_result_fifo2, a 2-entry IN_W-wide FIFO with push/pop/count and pop-and-push-same-cycle support.
- FSM, chunk mux and overflow logic stay in the top.

Test Plan:
- Single result, out_ready=1 constantly, in_data = 207'h1 <<192 | 16'hABCD:
  - out_valid high for exactly 13 consecutive cycles starting 1 cycle after in_valid.
  - Chunk 0 = 16'hABCD, chunks 1..11 = 0, chunk 12 = 16'h0001 with out_last=1.
  - busy falls the cycle after the last transfer.
- Backpressure: same input, out_ready toggling 1,0,0,1,... -> 13 transfers total, and out_data/out_last remain stable during every stall.
- Back-to-back: in_valid at cycles 0 and 1 with results A=all-ones, B=0, out_ready=1:
  - 26 contiguous valid cycles; the A chunks are 16'hFFFF ×12 then 16'h7FFF, followed by B chunks of 0.
  - No overflow.
- Overflow: out_ready=0, three in_valid pulses (A, B, C) -> overflow pulses once after C. Raising out_ready afterwards streams only A then B.
- Pop-and-push same cycle: buffer full with A and B; C arrives in the same cycle as A's last-chunk handshake -> C accepted, no overflow, and the stream order is A, B, C.
- Reset mid-stream: assert rst_n=1 during chunk 5 of A -> outputs zero the following cycle, busy=0. A new result afterward restarts at chunk 0.
